// File: rtl/ascii_dec_stream2bin.sv
// Streaming ASCII decimal field decoder: accumulates digits until a delimiter, then
// presents the binary value with error flag and digit count. Optional macro ASCII_DEC_SIGN_EN.
module ascii_dec_stream2bin #(
  parameter int p_nbits      = 16,
  parameter int p_max_digits = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [7:0]         in_char,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_value,
  output logic               out_err,
  output logic [3:0]         out_ndigits
);

  localparam int W = p_nbits + 4;
`ifdef ASCII_DEC_SIGN_EN
  localparam logic [W-1:0] LIM_POS = (W'(1) << (p_nbits - 1)) - W'(1);
  localparam logic [W-1:0] LIM_NEG = W'(1) << (p_nbits - 1);
`else
  localparam logic [W-1:0] LIM_POS = (W'(1) << p_nbits) - W'(1);
  localparam logic [W-1:0] LIM_NEG = LIM_POS;
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state, state_nx;
  logic [p_nbits-1:0] acc, acc_nx;
  logic [3:0]         count, count_nx, count_inc;
  logic               err, err_nx;
  logic               neg, neg_nx;
  logic               is_digit, is_delim, fire, load_out, final_err;
  logic [3:0]         dval;
  logic [W-1:0]       mac, lim;
  logic [p_nbits-1:0] value_nx;
`ifdef ASCII_DEC_SIGN_EN
  logic               is_minus;
  assign is_minus = (in_char == 8'h2D);
`endif

  assign in_rdy  = (state != DONE);
  assign out_val = (state == DONE);

  always_comb begin
    is_digit  = (in_char >= 8'h30) && (in_char <= 8'h39);
    is_delim  = (in_char == 8'h0A) || (in_char == 8'h0D) || (in_char == 8'h20);
    dval      = in_char[3:0];
    fire      = in_val && in_rdy;
    // Full-width multiply-add so an out-of-range value can never wrap into range
    mac       = W'(acc) * W'(10) + W'(dval);
    lim       = neg ? LIM_NEG : LIM_POS;
    count_inc = (count == 4'd15) ? count : count + 4'd1;
    // A field with no digits at all (e.g. a lone sign) is malformed
    final_err = err || (count == 4'd0);
    value_nx  = final_err ? '0 : (neg ? (~acc + p_nbits'(1)) : acc);

    state_nx = state;
    acc_nx   = acc;
    count_nx = count;
    err_nx   = err;
    neg_nx   = neg;
    load_out = 1'b0;

    case (state)
      IDLE: begin
        if (fire) begin
          if (is_digit) begin
            acc_nx   = p_nbits'(dval);
            count_nx = 4'd1;
            state_nx = ACCUM;
          end
`ifdef ASCII_DEC_SIGN_EN
          else if (is_minus) begin
            neg_nx   = 1'b1;
            state_nx = ACCUM;
          end
`endif
          else if (!is_delim) begin
            err_nx   = 1'b1;
            state_nx = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (fire) begin
          if (is_digit) begin
            acc_nx   = mac[p_nbits-1:0];
            count_nx = count_inc;
            if ((mac > lim) || (int'(count_inc) > p_max_digits)) err_nx = 1'b1;
          end else if (is_delim) begin
            load_out = 1'b1;
            state_nx = DONE;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_rdy) begin
          acc_nx   = '0;
          count_nx = '0;
          err_nx   = 1'b0;
          neg_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      err         <= 1'b0;
      neg         <= 1'b0;
      out_value   <= '0;
      out_err     <= 1'b0;
      out_ndigits <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      count <= count_nx;
      err   <= err_nx;
      neg   <= neg_nx;
      if (load_out) begin
        out_value   <= value_nx;
        out_err     <= final_err;
        out_ndigits <= count;
      end
    end
  end

endmodule

// File: tb/tb_ascii_dec_stream2bin.sv
// Randomized bench for ascii_dec_stream2bin against a field-level reference model.
module tb_ascii_dec_stream2bin;

  localparam int NB = 16;
  localparam int MD = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_val = 1'b0;
  logic          in_rdy;
  logic [7:0]    in_char = 8'h00;
  logic          out_val;
  logic          out_rdy = 1'b0;
  logic [NB-1:0] out_value;
  logic          out_err;
  logic [3:0]    out_ndigits;

  ascii_dec_stream2bin #(.p_nbits(NB), .p_max_digits(MD)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_char(in_char),
    .out_val(out_val), .out_rdy(out_rdy),
    .out_value(out_value), .out_err(out_err), .out_ndigits(out_ndigits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] value;
    logic          err;
    logic [3:0]    nd;
  } res_t;

  res_t       expq[$];
  logic [7:0] txq[$];
  logic [7:0] tok[$];
  int n_cmp = 0;
  int n_bad = 0;
  int gap_pct = 0;
  int rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled
  logic in_fire = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_delim(input logic [7:0] c);
    return (c == 8'h0A) || (c == 8'h0D) || (c == 8'h20);
  endfunction

  // Reference: a field is the run of non-delimiter characters closed by a delimiter
  task automatic close_token();
    longint v = 0;
    longint lim;
    int nd = 0;
    bit e = 0, neg = 0, big = 0;
    res_t r;
`ifdef ASCII_DEC_SIGN_EN
    neg = (tok[0] == 8'h2D);
    lim = neg ? (64'd1 << (NB - 1)) : (64'd1 << (NB - 1)) - 1;
`else
    lim = (64'd1 << NB) - 1;
`endif
    foreach (tok[i]) begin
      if (tok[i] >= 8'h30 && tok[i] <= 8'h39) begin
        nd++;
        if (!big) begin
          v = v * 10 + longint'(tok[i] - 8'h30);
          if (v > lim) big = 1;
        end
      end else if (!(neg && i == 0)) begin
        e = 1;
      end
    end
    if (nd > MD || big || (neg && nd == 0)) e = 1;
    r.err   = e;
    r.nd    = (nd > 15) ? 4'd15 : 4'(nd);
    r.value = e ? '0 : (neg ? NB'(-v) : NB'(v));
    expq.push_back(r);
    tok.delete();
  endtask

  task automatic push_char(input logic [7:0] c);
    txq.push_back(c);
    if (is_delim(c)) begin
      if (tok.size() > 0) close_token();
    end else begin
      tok.push_back(c);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) push_char(s[i]);
  endtask

  function automatic logic [7:0] rand_delim();
    case ($urandom_range(0, 2))
      0: return 8'h0A;
      1: return 8'h0D;
      default: return 8'h20;
    endcase
  endfunction

  task automatic rand_field();
    string s;
    logic [7:0] junk;
    junk = 8'h41 + 8'($urandom_range(0, 25));
    if ($urandom_range(0, 5) == 0) push_char(rand_delim());
    if ($urandom_range(0, 7) == 0) push_char(8'h2D);
    case ($urandom_range(0, 9))
      0: s = $sformatf("%0d", $urandom_range(65530, 65540));
      1: s = $sformatf("%0d", $urandom_range(32760, 32775));
      2: s = $sformatf("%0d", $urandom_range(100000, 999999));
      3: s = $sformatf("%0d%c%0d", $urandom_range(0, 99), junk, $urandom_range(0, 9));
      4: s = "0000";
      5: s = "00000012";
      6: s = $sformatf("%c", junk);
      default: s = $sformatf("%0d", $urandom_range(0, 99999));
    endcase
    send_str(s);
    push_char(rand_delim());
  endtask

  // Driver: present chars after each edge, valid held until accepted
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (in_fire) void'(txq.pop_front());
      if (!(in_val && !in_fire)) begin
        if (txq.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
          in_val  = 1'b1;
          in_char = txq[0];
        end else begin
          in_val = 1'b0;
        end
      end
      case (rdy_mode)
        0: out_rdy = ($urandom_range(0, 1) == 1);
        1: out_rdy = 1'b1;
        default: out_rdy = 1'b0;
      endcase
    end
  end

  // Monitor on the falling edge: handshakes seen here complete at the next rising edge
  logic          prev_out_val = 1'b0;
  logic          prev_stall = 1'b0;
  logic          delim_prev = 1'b0;
  logic [NB-1:0] held_value;
  logic          held_err;
  logic [3:0]    held_nd;
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("in_rdy_vs_out_val", in_rdy, !out_val);
        if (out_val && !prev_out_val) check("out_val_latency", delim_prev, 1);
        if (out_val && prev_stall) begin
          check("stall_value", out_value, held_value);
          check("stall_err", out_err, held_err);
          check("stall_ndigits", out_ndigits, held_nd);
        end
        if (out_val && out_rdy) begin
          if (expq.size() == 0) check("unexpected_result", out_val, 0);
          else begin
            r = expq.pop_front();
            check("value", out_value, r.value);
            check("err", out_err, r.err);
            check("ndigits", out_ndigits, r.nd);
          end
        end
        prev_stall = out_val && !out_rdy;
        held_value = out_value;
        held_err   = out_err;
        held_nd    = out_ndigits;
        delim_prev = in_val && in_rdy && is_delim(in_char);
        in_fire    = in_val && in_rdy;
      end else begin
        prev_stall = 1'b0;
        delim_prev = 1'b0;
        in_fire    = 1'b0;
      end
      prev_out_val = out_val;
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while ((txq.size() != 0 || in_val || expq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("drain_timeout", txq.size() + expq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_out_val(input int budget);
    int n = 0;
    while (!out_val && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!out_val) check("wait_out_val_timeout", out_val, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_val"}, out_val, 0);
    check({tag, "_out_value"}, out_value, 0);
    check({tag, "_out_err"}, out_err, 0);
    check({tag, "_out_ndigits"}, out_ndigits, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    tok.delete();
    expq.delete();
    @(posedge clk);
    @(negedge clk);
    check_zero("in_reset");
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    rdy_mode = 1;
    gap_pct  = 0;
    send_str("123\n");
    drain(100);
    send_str("65535 65536 123456\n");
    drain(200);
    send_str("  \r7\n1a2\n3\n");
    drain(200);

    rdy_mode = 2;
    send_str("42\n9");
    wait_out_val(50);
    repeat (4) begin
      @(negedge clk);
      check("stall_in_rdy", in_rdy, 0);
    end
    check("held_char_valid", in_val, 1);
    check("held_char_pending", txq.size(), 1);
    rdy_mode = 1;
    send_str("\n");
    drain(100);

    send_str("98");
    drain(100);
    pulse_reset();
    send_str("5\n");
    drain(100);

    rdy_mode = 2;
    send_str("77\n");
    wait_out_val(50);
    pulse_reset();
    rdy_mode = 1;
    send_str("6 x5\n-5\n");
    drain(200);

`ifdef ASCII_DEC_SIGN_EN
    send_str("-32768\n-32769\n32768\n-\n5-\n-0 32767\n");
    drain(300);
`endif

    rdy_mode = 0;
    gap_pct  = 30;
    for (int f = 0; f < 300; f++) rand_field();
    drain(20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
